fwd_scoreboard: RTL and testbench

Parametrised forwarding and interlock scoreboard for the PCPU back-end. It keeps a shift-register record of every register-writing instruction in flight between ID/EX and write-back. For each of `NUM_READ` source operands it returns a one-hot bypass select naming the youngest in-flight producer. If that producer's result is not yet available, it raises a pipeline interlock. It generalises the fixed two-source, two-stage forwarding decode with configurable depth, read-port count and per-instruction result latency, and it generates load-use stalls itself.

---
 rtl/fwd_scoreboard.sv | 67 ++++++
 tb/tb_fwd_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writers and, for each operand port,
// selects the youngest producer for bypass and raises an interlock if it is not ready.
module fwd_scoreboard #(
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 3,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_regwrite,
  input  logic [LW-1:0]           issue_lat,
  input  logic [NUM_READ-1:0]     rd_en,
  input  logic [NUM_READ*5-1:0]   rd_addr,
  output logic [NUM_READ*DEPTH-1:0] fwd_sel,
  output logic [NUM_READ-1:0]     fwd_hit,
  output logic                    stall,
  output logic [31:0]             stall_cnt
);
  logic [DEPTH-1:0]    v, nz;
  logic [4:0]          rd  [DEPTH];
  logic [LW-1:0]       cnt [DEPTH];
  logic [NUM_READ-1:0] pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i]  <= '0;
        cnt[i] <= '0;
      end
    end else if (!hold) begin
      for (int i = 1; i < DEPTH; i++) begin
        v[i]   <= v[i-1];
        rd[i]  <= rd[i-1];
        cnt[i] <= (cnt[i-1] == '0) ? '0 : cnt[i-1] - LW'(1);
      end
      // a stalled or flushed issue becomes a bubble; x0 writers are never tracked
      v[0]   <= issue_valid & issue_regwrite & (issue_rd != 5'd0) & ~flush & ~stall;
      rd[0]  <= issue_rd;
      cnt[0] <= issue_lat;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) nz[i] = (cnt[i] != '0);
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [DEPTH-1:0] m, s;
    always_comb begin
      for (int i = 0; i < DEPTH; i++) m[i] = rd_en[p] & v[i] & (rd[i] == rd_addr[5*p +: 5]);
    end
    // isolate the lowest set bit: the youngest matching stage
    assign s = m & (~m + DEPTH'(1));
    assign fwd_sel[p*DEPTH +: DEPTH] = s;
    assign fwd_hit[p] = |m;
    assign pend[p]    = |(s & nz);
  end

  assign stall = |pend;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vector table, hold/reset sequence and randomized
// stimulus against a queue-based reference model of in-flight writers.
module tb_fwd_scoreboard;
  localparam int NR = 2;
  localparam int D  = 3;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst, hold, flush, issue_valid, issue_regwrite;
  logic [4:0]      issue_rd;
  logic [LW-1:0]   issue_lat;
  logic [NR-1:0]   rd_en;
  logic [NR*5-1:0] rd_addr;
  logic [NR*D-1:0] fwd_sel;
  logic [NR-1:0]   fwd_hit;
  logic            stall;
  logic [31:0]     stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_scoreboard #(.NUM_READ(NR), .DEPTH(D), .LW(LW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_regwrite(issue_regwrite),
    .issue_lat(issue_lat), .rd_en(rd_en), .rd_addr(rd_addr),
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rd;
    logic [1:0] lat;
    logic [1:0] en;
    logic [4:0] a0, a1;
    logic       h, f;
    logic [5:0] sel;
    logic       st;
    int         sc;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    int         lat;
    int         age;
  } rec_t;

  rec_t        q[$];
  logic [31:0] m_scnt = 0;

  function automatic vec_t mk(logic iv, logic [4:0] rd, logic [1:0] lat, logic [1:0] en,
                              logic [4:0] a0, logic [4:0] a1, logic h, logic f,
                              logic [5:0] sel, logic st, int sc);
    vec_t r;
    r.iv = iv; r.rd = rd; r.lat = lat; r.en = en; r.a0 = a0; r.a1 = a1;
    r.h = h; r.f = f; r.sel = sel; r.st = st; r.sc = sc;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic iv, logic [4:0] rd, logic [1:0] lat, logic [1:0] en,
                       logic [4:0] a0, logic [4:0] a1, logic h, logic f);
    issue_valid = iv; issue_rd = rd; issue_lat = lat; rd_en = en;
    rd_addr = {a1, a0}; hold = h; flush = f; issue_regwrite = 1'b1;
  endtask

  // Reference: records keyed by age (advances since issue); ready once age >= latency.
  task automatic model_eval(output logic [5:0] sel, output logic st);
    sel = '0;
    st  = 1'b0;
    for (int p = 0; p < NR; p++) begin
      int best;
      logic [4:0] a;
      best = -1;
      a = rd_addr[5*p +: 5];
      if (rd_en[p])
        foreach (q[k]) if (q[k].rd == a && (best < 0 || q[k].age < q[best].age)) best = k;
      if (best >= 0) begin
        sel[p*D + q[best].age] = 1'b1;
        if (q[best].age < q[best].lat) st = 1'b1;
      end
    end
  endtask

  task automatic model_step(logic st);
    rec_t r;
    if (hold) return;
    if (st && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    foreach (q[k]) q[k].age++;
    for (int k = q.size() - 1; k >= 0; k--) if (q[k].age >= D) q.delete(k);
    if (issue_valid && issue_regwrite && issue_rd != 0 && !flush && !st) begin
      r.rd = issue_rd; r.lat = int'(issue_lat); r.age = 0;
      q.push_front(r);
    end
  endtask

  vec_t tbl[19];
  logic [5:0] esel;
  logic       est;

  initial begin
    tbl[0]  = mk(1, 5, 0, 2'b00,  0, 0, 0, 0, 6'b000000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 2'b01,  5, 0, 0, 0, 6'b000001, 0, 0);
    tbl[2]  = mk(0, 0, 0, 2'b01,  5, 0, 0, 0, 6'b000010, 0, 0);
    tbl[3]  = mk(0, 0, 0, 2'b01,  5, 0, 0, 0, 6'b000100, 0, 0);
    tbl[4]  = mk(1, 7, 1, 2'b01,  5, 0, 0, 0, 6'b000000, 0, 0);
    tbl[5]  = mk(1, 9, 0, 2'b10,  0, 7, 0, 0, 6'b001000, 1, 0);
    tbl[6]  = mk(0, 0, 0, 2'b11,  9, 7, 0, 0, 6'b010000, 0, 1);
    tbl[7]  = mk(1, 3, 0, 2'b00,  0, 0, 0, 0, 6'b000000, 0, 1);
    tbl[8]  = mk(0, 0, 0, 2'b00,  0, 0, 0, 0, 6'b000000, 0, 1);
    tbl[9]  = mk(1, 3, 0, 2'b00,  0, 0, 0, 0, 6'b000000, 0, 1);
    tbl[10] = mk(1, 3, 1, 2'b01,  3, 0, 0, 0, 6'b000001, 0, 1);
    tbl[11] = mk(0, 0, 0, 2'b01,  3, 0, 0, 0, 6'b000001, 1, 1);
    tbl[12] = mk(1, 0, 0, 2'b01,  3, 0, 0, 0, 6'b000010, 0, 2);
    tbl[13] = mk(1, 9, 0, 2'b11,  0, 0, 0, 0, 6'b000000, 0, 2);
    tbl[14] = mk(1, 10, 0, 2'b10, 9, 9, 0, 1, 6'b001000, 0, 2);
    tbl[15] = mk(1, 12, 1, 2'b01, 10, 0, 0, 0, 6'b000000, 0, 2);
    tbl[16] = mk(0, 0, 0, 2'b01, 12, 0, 1, 0, 6'b000001, 1, 2);
    tbl[17] = mk(0, 0, 0, 2'b01, 12, 0, 1, 0, 6'b000001, 1, 2);
    tbl[18] = mk(0, 0, 0, 2'b01, 12, 0, 1, 0, 6'b000001, 1, 2);

    rst = 1'b1;
    drive(0, 0, 0, 2'b11, 5, 5, 0, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset_sel", fwd_sel, 0);
      chk("reset_stall", stall, 0);
      chk("reset_cnt", stall_cnt, 0);
    end
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].iv, tbl[k].rd, tbl[k].lat, tbl[k].en, tbl[k].a0, tbl[k].a1, tbl[k].h, tbl[k].f);
      #1;
      chk($sformatf("vec%0d_sel", k), fwd_sel, tbl[k].sel);
      chk($sformatf("vec%0d_hit", k), fwd_hit, {|tbl[k].sel[5:3], |tbl[k].sel[2:0]});
      chk($sformatf("vec%0d_stall", k), stall, tbl[k].st);
      chk($sformatf("vec%0d_cnt", k), stall_cnt, 64'(tbl[k].sc));
    end

    // still held in the load-use stall; then an asynchronous reset mid-cycle
    @(negedge clk);
    #1;
    chk("hold_stall", stall, 1);
    chk("hold_cnt", stall_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    chk("async_rst_sel", fwd_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 5, 0, 2'b01, 5, 0, 0, 0);
    #1;
    chk("post_rst_empty", fwd_sel, 0);
    @(negedge clk);
    drive(0, 0, 0, 2'b01, 5, 0, 0, 0);
    #1;
    chk("post_rst_load", fwd_sel, 6'b000001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    q.delete();
    m_scnt = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      issue_valid    = 1'($urandom_range(0, 1));
      issue_regwrite = ($urandom_range(0, 9) != 0);
      issue_rd       = 5'($urandom_range(0, 7));
      issue_lat      = LW'($urandom_range(0, 3));
      rd_en          = NR'($urandom);
      rd_addr        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      hold           = ($urandom_range(0, 99) < 15);
      flush          = ($urandom_range(0, 99) < 10);
      #1;
      model_eval(esel, est);
      chk("rnd_sel", fwd_sel, esel);
      chk("rnd_hit", fwd_hit, {|esel[5:3], |esel[2:0]});
      chk("rnd_stall", stall, est);
      chk("rnd_cnt", stall_cnt, m_scnt);
      @(posedge clk);
      model_step(est);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
